// File: rtl/btn_event_pkg.sv
// Shared types and default timing constants for the button event classifier.
package btn_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_LONG_CYCLES   = 50000000;
  localparam int DEF_REPEAT_CYCLES = 12500000;

endpackage

// File: rtl/level_sync.sv
// N-flop level synchronizer for an asynchronous input; clears to 0 on reset.
module level_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/btn_event_gen.sv
// Turns a debounced button level into registered press/release/long/repeat
// pulses plus a held flag and a wrapping press count.
module btn_event_gen
  import btn_event_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_db,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  logic s, s_prev, rise, fall;

  level_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_db),
    .q   (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_prev <= 1'b0;
    else     s_prev <= s;
  end

  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n, rel_n, long_n, rep_n, held_n;
  logic [7:0]       pcnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_cnt     <= 8'd0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      press_pulse   <= press_n;
      release_pulse <= rel_n;
      long_pulse    <= long_n;
      repeat_pulse  <= rep_n;
      held          <= held_n;
      press_cnt     <= pcnt_n;
    end
  end

  // Release takes priority over a terminal count landing in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    rep_n   = 1'b0;
    pcnt_n  = press_cnt;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          state_n = PRESSED;
          press_n = 1'b1;
          pcnt_n  = press_cnt + 8'd1;
        end else if (fall) begin
          rel_n = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_n = IDLE;
          cnt_n   = '0;
          rel_n   = 1'b1;
        end else if (cnt == LONG_TC) begin
          state_n = HELD;
          cnt_n   = '0;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (fall) begin
          state_n = IDLE;
          cnt_n   = '0;
          rel_n   = 1'b1;
        end else if (cnt == REP_TC) begin
          cnt_n = '0;
          rep_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    held_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with short timing (LONG=8, REPEAT=4).
module tb_btn_event_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_db = 1'b0;
  logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // per-run observations, edge indices relative to E0
  int p_at, r_at, l_at, rp_first, rp_last;
  int p_n, r_n, l_n, rp_n, h_n, ov_n;

  btn_event_gen #(
    .SYNC_STAGES   (2),
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_db        (btn_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_cnt     (press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_cnt});
  endfunction

  task automatic clr_stats();
    p_at = -1; r_at = -1; l_at = -1; rp_first = -1; rp_last = -1;
    p_n = 0; r_n = 0; l_n = 0; rp_n = 0; h_n = 0; ov_n = 0;
  endtask

  task automatic sample(input int k);
    if (press_pulse)   begin p_n++; if (p_at < 0) p_at = k; end
    if (release_pulse) begin r_n++; if (r_at < 0) r_at = k; end
    if (long_pulse)    begin l_n++; if (l_at < 0) l_at = k; end
    if (repeat_pulse)  begin rp_n++; if (rp_first < 0) rp_first = k; rp_last = k; end
    if (held) h_n++;
    if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1)
      ov_n++;
  endtask

  // Called just after a posedge: btn_db rises before E0, falls before E(hold).
  task automatic run_press(input int hold, input int ncyc);
    clr_stats();
    btn_db = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      sample(k);
      if (k == hold - 1) btn_db = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // short press
    run_press(5, 12);
    chk("short_press_at", p_at, 2);
    chk("short_press_n", p_n, 1);
    chk("short_rel_at", r_at, 7);
    chk("short_long_n", l_n, 0);
    chk("short_held_n", h_n, 5);
    chk("short_cnt", press_cnt, 1);

    // long press with repeats
    run_press(20, 26);
    chk("long_press_at", p_at, 2);
    chk("long_long_at", l_at, 10);
    chk("long_long_n", l_n, 1);
    chk("long_rep_n", rp_n, 2);
    chk("long_rep_first", rp_first, 14);
    chk("long_rep_last", rp_last, 18);
    chk("long_rel_at", r_at, 22);
    chk("long_held_n", h_n, 20);
    chk("long_held_after", held, 0);
    chk("long_cnt", press_cnt, 2);
    chk("long_overlap", ov_n, 0);

    // release on the long terminal count
    run_press(8, 14);
    chk("coll_press_at", p_at, 2);
    chk("coll_rel_at", r_at, 10);
    chk("coll_long_n", l_n, 0);
    chk("coll_held_n", h_n, 8);
    chk("coll_cnt", press_cnt, 3);

    // single-cycle glitch
    run_press(1, 6);
    chk("glitch_press_at", p_at, 2);
    chk("glitch_rel_at", r_at, 3);
    chk("glitch_press_n", p_n, 1);
    chk("glitch_rel_n", r_n, 1);
    chk("glitch_held_n", h_n, 1);
    chk("glitch_cnt", press_cnt, 4);

    // reset while in HELD with button still down
    clr_stats();
    btn_db = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      sample(k);
    end
    chk("mid_long_seen", l_n, 1);
    chk("mid_held_pre", held, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", outs(), 0);
    @(posedge clk); #1;
    chk("mid_rst_hold_outs", outs(), 0);
    rst = 1'b0;
    clr_stats();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      sample(k);
      if (k == 2) chk("mid_cnt_after_press", press_cnt, 1);
    end
    chk("mid_press_at", p_at, 2);
    chk("mid_long_at", l_at, 10);
    btn_db = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_idle_held", held, 0);

    // press counter wrap from a clean reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 255; i++) run_press(1, 5);
    chk("wrap_cnt_255", press_cnt, 255);
    run_press(1, 5);
    chk("wrap_cnt_256", press_cnt, 0);
    run_press(1, 5);
    chk("wrap_cnt_257", press_cnt, 1);
    chk("wrap_press_at", p_at, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
